// File: rtl/operand_sequencer_pkg.sv
// seq_pkg: shared state encoding and default sizes for the operand sequencer
package seq_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, HOLD, REPORT} seq_state_t;
  localparam int OPW = 4;
  localparam int DEFAULT_SETTLE = 2;
endpackage

// File: rtl/operand_sequencer_if.sv
// operand_sequencer_if: nibble input, operand fan-out, chain feedback and result port
interface operand_sequencer_if
  import seq_pkg::*;
#(
  parameter int WIDTH = OPW,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic             altb;
  logic             res_valid;
  logic             res_ready;
  logic             res_altb;
  logic [CNT_W-1:0] lt_count;
  logic             busy;
  modport master (
    input  in_valid, in_data, altb, res_ready,
    output in_ready, a, b, c, d, res_valid, res_altb, lt_count, busy
  );
  modport slave (
    output in_valid, in_data, altb, res_ready,
    input  in_ready, a, b, c, d, res_valid, res_altb, lt_count, busy
  );
endinterface

// File: rtl/operand_sequencer_sat_counter.sv
// sat_counter: up-counter with sync clear that sticks at all-ones
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clock)
    if (reset) q <= '0;
    else if (inc && !(&q)) q <= q + W'(1);
endmodule

// File: rtl/operand_sequencer.sv
// operand_sequencer: gathers a,b,c,d nibbles, holds them for the chain, returns sampled altb
module operand_sequencer
  import seq_pkg::*;
#(
  parameter int WIDTH  = OPW,
  parameter int SETTLE = DEFAULT_SETTLE,
  parameter int CNT_W  = 8
) (
  input logic clock,
  input logic reset,
  operand_sequencer_if.master bus
);
  localparam int SW = $clog2(SETTLE + 1);
  seq_state_t       state, nxt;
  logic [1:0]       idx;
  logic [SW-1:0]    settle_cnt;
  logic [WIDTH-1:0] opnd [4];
  logic             res_altb_q, acc, done, fire;
  always_comb begin
    bus.in_ready = state == IDLE || state == LOAD;
    acc  = bus.in_valid && bus.in_ready;
    done = state == HOLD && settle_cnt == SW'(SETTLE - 1);
    fire = state == REPORT && bus.res_ready;
    nxt  = state == IDLE ? (acc ? LOAD : IDLE) :
           state == LOAD ? (acc && idx == 2'd3 ? HOLD : LOAD) :
           state == HOLD ? (done ? REPORT : HOLD) :
                           (fire ? IDLE : REPORT);
  end
  always_ff @(posedge clock)
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      settle_cnt <= '0;
      opnd       <= '{default: '0};
      res_altb_q <= 1'b0;
    end else begin
      state <= nxt;
      if (acc) begin
        opnd[idx] <= bus.in_data;
        idx       <= idx + 2'd1;
      end
      settle_cnt <= (acc && idx == 2'd3) ? '0 : state == HOLD ? settle_cnt + SW'(1) : settle_cnt;
      if (done) res_altb_q <= bus.altb;
    end
  assign bus.a         = opnd[0];
  assign bus.b         = opnd[1];
  assign bus.c         = opnd[2];
  assign bus.d         = opnd[3];
  assign bus.res_valid = state == REPORT;
  assign bus.res_altb  = res_altb_q;
  assign bus.busy      = state != IDLE;
  sat_counter #(.W(CNT_W)) u_cnt (
    .clock(clock),
    .reset(reset),
    .inc  (fire && res_altb_q),
    .q    (bus.lt_count)
  );
endmodule

// File: tb/tb_operand_sequencer.sv
// tb_operand_sequencer: random quads through two sequencers (8- and 2-bit counters) with a behavioural chain
module tb_operand_sequencer;
  import seq_pkg::*;
  localparam int SETTLE = DEFAULT_SETTLE;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       res_ready = 1'b0;
  logic [3:0] in_data = '0;
  int checks = 0, failures = 0;
  int cnt8 = 0, cnt2 = 0;
  operand_sequencer_if #(.WIDTH(4), .CNT_W(8)) b1 ();
  operand_sequencer_if #(.WIDTH(4), .CNT_W(2)) b2 ();
  assign b1.in_valid  = in_valid;
  assign b1.in_data   = in_data;
  assign b1.res_ready = res_ready;
  assign b2.in_valid  = in_valid;
  assign b2.in_data   = in_data;
  assign b2.res_ready = res_ready;
  // adder/subtractor/comparator chain, modulo 16
  assign b1.altb = 4'(b1.a + b1.b) < 4'(b1.c - b1.d);
  assign b2.altb = 4'(b2.a + b2.b) < 4'(b2.c - b2.d);
  operand_sequencer #(.WIDTH(4), .SETTLE(SETTLE), .CNT_W(8)) dut8 (.clock(clock), .reset(reset), .bus(b1.master));
  operand_sequencer #(.WIDTH(4), .SETTLE(SETTLE), .CNT_W(2)) dut2 (.clock(clock), .reset(reset), .bus(b2.master));
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic [3:0] dat, input logic rr);
    @(posedge clock);
    #1;
    in_valid  = v;
    in_data   = dat;
    res_ready = rr;
    @(negedge clock);
  endtask

  task automatic check_idle();
    check("rst_in_ready", b1.in_ready, 1);
    check("rst_busy", b1.busy, 0);
    check("rst_res_valid", b1.res_valid, 0);
    check("rst_res_altb", b1.res_altb, 0);
    check("rst_abcd", {b1.a, b1.b, b1.c, b1.d}, 0);
    check("rst_lt8", b1.lt_count, 0);
    check("rst_lt2", b2.lt_count, 0);
  endtask

  task automatic quad(input logic [3:0] q0, input logic [3:0] q1, input logic [3:0] q2,
                      input logic [3:0] q3, input int gap_pct, input int bp);
    logic [3:0] q [4];
    logic       v, exp_lt;
    int         i, n;
    q      = '{q0, q1, q2, q3};
    exp_lt = 4'(q0 + q1) < 4'(q2 - q3);
    i = 0;
    n = 0;
    while (i < 4 && n < 200) begin
      v = $urandom_range(99) >= gap_pct;
      step(v, v ? q[i] : 4'($urandom), 1'($urandom));
      check("in_ready_load", b1.in_ready, 1);
      check("busy_load", b1.busy, i > 0);
      check("res_valid_load", b1.res_valid, 0);
      if (v) i++;
      n++;
    end
    if (i < 4) check("load_timeout", i, 4);
    for (int s = 0; s < SETTLE; s++) begin
      step(1'b1, 4'($urandom), 1'($urandom));
      check("in_ready_hold", b1.in_ready, 0);
      check("res_valid_hold", b1.res_valid, 0);
      check("busy_hold", b1.busy, 1);
    end
    for (int k = 0; k <= bp; k++) begin
      step(1'b1, 4'($urandom), k == bp);
      check("res_valid_rep", b1.res_valid, 1);
      check("res_altb8", b1.res_altb, exp_lt);
      check("res_altb2", b2.res_altb, exp_lt);
      check("in_ready_rep", b1.in_ready, 0);
      check("abcd_rep", {b1.a, b1.b, b1.c, b1.d}, {q0, q1, q2, q3});
    end
    if (exp_lt) begin
      cnt8 = cnt8 < 255 ? cnt8 + 1 : 255;
      cnt2 = cnt2 < 3 ? cnt2 + 1 : 3;
    end
    step(1'b0, 4'($urandom), 1'b0);
    check("res_valid_idle", b1.res_valid, 0);
    check("in_ready_idle", b1.in_ready, 1);
    check("busy_idle", b1.busy, 0);
    check("lt_count8", b1.lt_count, cnt8);
    check("lt_count2", b2.lt_count, cnt2);
    check("abcd_idle", {b1.a, b1.b, b1.c, b1.d}, {q0, q1, q2, q3});
  endtask

  task automatic reset_in_hold();
    logic [3:0] q [4];
    q = '{4'd1, 4'd2, 4'd9, 4'd4};
    for (int i = 0; i < 4; i++) step(1'b1, q[i], 1'b0);
    step(1'b1, 4'hf, 1'b0);
    check("busy_pre_rst", b1.busy, 1);
    @(posedge clock);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    cnt8 = 0;
    cnt2 = 0;
    check_idle();
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'h0, 1'b1);
      check("no_result_after_rst", b1.res_valid, 0);
      check("lt_after_rst", b1.lt_count, 0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check_idle();
    quad(4'd9, 4'd4, 4'd9, 4'd4, 0, 0);
    quad(4'd1, 4'd2, 4'd9, 4'd4, 0, 0);
    quad(4'd9, 4'd4, 4'd0, 4'd4, 0, 0);
    quad(4'd1, 4'd2, 4'd9, 4'd4, 0, 5);
    quad(4'd3, 4'd7, 4'd12, 4'd1, 50, 0);
    reset_in_hold();
    repeat (5) quad(4'd1, 4'd2, 4'd9, 4'd4, 0, 0);
    repeat (40)
      quad(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
           $urandom_range(60), $urandom_range(4));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
